spi_wb_bridge: RTL and testbench
================================

# spi_wb_bridge

SPI responder (mode 0) that bridges an external SPI controller onto the user-area Wishbone bus as a Wishbone master. It is the far end of the `tiny_spi` controller link: a board-level or second-chip SPI master issues framed read/write commands, and the block turns each frame into exactly one 32-bit Wishbone access. It sits on the GPIO pads beside the UART and SPI pins and drives a master port of the interconnect.

## Interface
Parameters:
- TIMEOUT, 48, maximum wb_clk_i cycles to wait for wbm_ack_i. Must be less than 8*(SCLK period in wb_clk_i cycles) - 8.
- ERR_DATA, 32'hFFFF_FFFF, read data returned when an access times out.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- spi_sclk_i  in  1  SPI clock, asynchronous to wb_clk_i. Frequency is at most wb_clk_i/8.
- spi_csn_i  in  1  chip select, active low, asynchronous.
- spi_mosi_i  in  1  serial data in.
- spi_miso_o  out  1  serial data out.
- spi_miso_oeb_o  out  1  pad output-enable bar. 1 means high-Z; it is 1 whenever CS is high.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone master control.
- wbm_adr_o  out  32  byte address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  always 4'hF during a cycle.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  acknowledge.
- err_o  out  1  one-cycle pulse on a Wishbone timeout.
- busy_o  out  1  high from CS falling edge until the frame ends or the Wishbone cycle completes, whichever is later.

## Operation
- **Synchronisation:** spi_sclk_i, spi_csn_i and spi_mosi_i each pass through 2-FF synchronisers. Edges are detected on the synchronised SCLK.
  - MOSI is sampled on the SCLK rising edge.
  - MISO is updated on the SCLK falling edge.
  - The next MISO bit is presented on the CS falling edge.
- **Frame format:** all fields are MSB first.
  - Command byte: 8'h02 = write, 8'h03 = read.
  - Address: 32 bits.
  - Write frame: 32 data bits follow the address.
  - Read frame: 8 dummy bits, then 32 data bits driven on MISO.
- **Frame FSM:**
  - IDLE → CMD when CS falls.
  - CMD → ADDR after 8 bits if the command is valid, otherwise → IGNORE.
  - ADDR → WDATA (write) or RDUMMY (read) after 32 bits.
  - WDATA → DONE after 32 bits.
  - RDUMMY → RDATA after 8 bits.
  - RDATA → DONE after 32 bits.
  - DONE and IGNORE discard further bits until CS rises.
  - A CS rise in any state returns the FSM to IDLE.
- **Wishbone engine (WB_IDLE, WB_BUSY):**
  - Write: launched on the cycle after the 32nd WDATA bit is sampled.
  - Read: launched on the cycle after the 32nd ADDR bit is sampled.
  - The engine asserts cyc/stb/we/adr/dat together and holds them until ack or timeout, then drops cyc/stb on the next cycle.
  - Read data is captured on ack. On timeout, ERR_DATA is captured and err_o pulses.
  - At the start of RDATA, the captured word is loaded into the shift register.
- **MISO content:** 0 in CMD, ADDR, WDATA, RDUMMY, DONE and IGNORE. Shift-register MSB in RDATA.
- **CS abort mid-frame:** the FSM returns to IDLE and bit counters clear.
  - A Wishbone cycle already in flight runs to ack or timeout; its result is discarded.
  - A write whose 32nd data bit was not sampled is never issued.
- **Short or long frames:** fewer bits means no access is issued. Bits beyond the frame are ignored.
- **Back-to-back frames:** a new frame may start while the engine is still WB_BUSY. Its access is launched only after the engine returns to WB_IDLE.

## Timing
- **Reset values:**
  - wbm_cyc_o, wbm_stb_o, wbm_we_o = 0.
  - wbm_adr_o, wbm_dat_o = 0.
  - wbm_sel_o = 0.
  - spi_miso_o = 0, spi_miso_oeb_o = 1.
  - err_o = 0, busy_o = 0.
  - FSM in IDLE, engine in WB_IDLE.
- **Edge latency:** a pin edge is acted on 3 wb_clk_i cycles later (2 synchroniser stages + 1 edge register).
- **Write issue:** cyc/stb rise 1 cycle after the internal rising-edge strobe of the final data bit.
- **Read budget:** the dummy byte gives at least 64 wb_clk_i cycles, so the read must complete (ack or timeout) before RDATA starts.
- **Ack handling:** ack is sampled every cycle while stb is high. A zero-wait ack in the first stb cycle is legal.
- **Timeout:** the counter starts at cycle 1 of stb. If no ack has arrived, stb drops after TIMEOUT cycles and err_o is high for exactly 1 cycle.
- **Simultaneous events:** a CS rise together with the final bit's rising edge still counts the bit.

## Test plan
- **Write:** frame 02, 00000010, CAFEBABE → one Wishbone write with adr=32'h10, dat=32'hCAFEBABE, sel=F, we=1; cyc held 1 cycle past ack; busy_o falls.
- **Read:** frame 03, 00000020 with slave returning 32'h12345678 after 3 cycles → MISO shifts 32'h12345678 MSB first during RDATA; MISO is 0 during the dummy byte.
- **Invalid command:** 8'h55 then 72 bits → no cyc assertion; MISO stays 0.
- **CS abort:** CS rises after 20 write-data bits → no Wishbone cycle; the next valid write frame works normally.
- **Read timeout:** slave never acks → err_o pulses once TIMEOUT=48 cycles after stb; MISO returns 32'hFFFFFFFF.
- **Async reset mid-access:** wb_rst_i asserted while stb is high → cyc/stb drop immediately with no clock edge; all outputs take their reset values.

Source files
------------

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 responder that turns each framed read/write command into a single
// 32-bit Wishbone master access on wb_clk_i.
module spi_wb_bridge #(
   parameter int          TIMEOUT  = 48,
   parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        spi_sclk_i,
   input  logic        spi_csn_i,
   input  logic        spi_mosi_i,
   output logic        spi_miso_o,
   output logic        spi_miso_oeb_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        err_o,
   output logic        busy_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDUMMY, S_RDATA, S_DONE, S_IGNORE
   } frame_state_t;

   typedef enum logic {WB_IDLE, WB_BUSY} wb_state_t;

   logic [2:0]   sclk_sync_q, sclk_sync_d;
   logic [2:0]   csn_sync_q, csn_sync_d;
   logic [1:0]   mosi_sync_q, mosi_sync_d;
   frame_state_t state_q, state_d;
   logic [4:0]   bit_cnt_q, bit_cnt_d;
   logic [31:0]  shift_q, shift_d;
   logic [31:0]  addr_q, addr_d;
   logic         is_write_q, is_write_d;
   logic [31:0]  rd_shift_q, rd_shift_d;
   logic         miso_q, miso_d;
   logic         oeb_q, oeb_d;
   wb_state_t    wb_state_q, wb_state_d;
   logic         cyc_q, cyc_d;
   logic         stb_q, stb_d;
   logic         we_q, we_d;
   logic [31:0]  adr_q, adr_d;
   logic [31:0]  dat_q, dat_d;
   logic [3:0]   sel_q, sel_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic [31:0]  rdata_q, rdata_d;
   logic         err_q, err_d;
   logic         busy_q, busy_d;
   logic         pend_q, pend_d;
   logic         pend_we_q, pend_we_d;
   logic [31:0]  pend_adr_q, pend_adr_d;
   logic [31:0]  pend_dat_q, pend_dat_d;

   logic         req_valid, req_we;
   logic [31:0]  req_adr, req_dat;
   logic         l_valid, l_we;
   logic [31:0]  l_adr, l_dat;

   logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit;
   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign cs_fall   = ~csn_sync_q[1] & csn_sync_q[2];
   assign cs_rise   = csn_sync_q[1] & ~csn_sync_q[2];
   assign mosi_bit  = mosi_sync_q[1];

   always_comb begin
      sclk_sync_d = {sclk_sync_q[1:0], spi_sclk_i};
      csn_sync_d  = {csn_sync_q[1:0], spi_csn_i};
      mosi_sync_d = {mosi_sync_q[0], spi_mosi_i};
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      addr_d      = addr_q;
      is_write_d  = is_write_q;
      rd_shift_d  = rd_shift_q;
      miso_d      = miso_q;
      oeb_d       = csn_sync_q[1];
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_adr     = addr_q;
      req_dat     = shift_q;

      if (cs_fall) begin
         state_d   = S_CMD;
         bit_cnt_d = '0;
         miso_d    = 1'b0;
      end else if (sclk_rise && state_q != S_IDLE && state_q != S_DONE && state_q != S_IGNORE) begin
         shift_d   = {shift_q[30:0], mosi_bit};
         bit_cnt_d = bit_cnt_q + 5'd1;
         case (state_q)
            S_CMD: if (bit_cnt_q == 5'd7) begin
               bit_cnt_d = '0;
               if (shift_d[7:0] == 8'h02) begin
                  state_d    = S_ADDR;
                  is_write_d = 1'b1;
               end else if (shift_d[7:0] == 8'h03) begin
                  state_d    = S_ADDR;
                  is_write_d = 1'b0;
               end else begin
                  state_d = S_IGNORE;
               end
            end
            S_ADDR: if (bit_cnt_q == 5'd31) begin
               bit_cnt_d = '0;
               addr_d    = shift_d;
               if (is_write_q) begin
                  state_d = S_WDATA;
               end else begin
                  // Reads go out now so the dummy byte covers the bus latency
                  state_d   = S_RDUMMY;
                  req_valid = 1'b1;
                  req_adr   = shift_d;
               end
            end
            S_WDATA: if (bit_cnt_q == 5'd31) begin
               bit_cnt_d = '0;
               state_d   = S_DONE;
               req_valid = 1'b1;
               req_we    = 1'b1;
               req_adr   = addr_q;
               req_dat   = shift_d;
            end
            S_RDUMMY: if (bit_cnt_q == 5'd7) begin
               bit_cnt_d  = '0;
               state_d    = S_RDATA;
               rd_shift_d = rdata_q;
            end
            S_RDATA: if (bit_cnt_q == 5'd31) begin
               bit_cnt_d = '0;
               state_d   = S_DONE;
            end
            default: ;
         endcase
      end else if (sclk_fall) begin
         if (state_q == S_RDATA) begin
            miso_d     = rd_shift_q[31];
            rd_shift_d = {rd_shift_q[30:0], 1'b0};
         end else begin
            miso_d = 1'b0;
         end
      end

      // A final bit arriving with the CS rise has already been counted above
      if (cs_rise) begin
         state_d   = S_IDLE;
         bit_cnt_d = '0;
         miso_d    = 1'b0;
      end

      wb_state_d = wb_state_q;
      cyc_d      = cyc_q;
      stb_d      = stb_q;
      we_d       = we_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      sel_d      = sel_q;
      to_cnt_d   = to_cnt_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      pend_d     = pend_q;
      pend_we_d  = pend_we_q;
      pend_adr_d = pend_adr_q;
      pend_dat_d = pend_dat_q;
      l_valid    = 1'b0;
      l_we       = 1'b0;
      l_adr      = '0;
      l_dat      = '0;

      if (wb_state_q == WB_IDLE && pend_q) begin
         l_valid = 1'b1;
         l_we    = pend_we_q;
         l_adr   = pend_adr_q;
         l_dat   = pend_dat_q;
         pend_d  = 1'b0;
      end else if (wb_state_q == WB_IDLE && req_valid) begin
         l_valid = 1'b1;
         l_we    = req_we;
         l_adr   = req_adr;
         l_dat   = req_dat;
      end

      // A request that cannot launch this cycle waits for the engine to go idle
      if (req_valid && !(l_valid && !pend_q)) begin
         pend_d     = 1'b1;
         pend_we_d  = req_we;
         pend_adr_d = req_adr;
         pend_dat_d = req_dat;
      end

      if (wb_state_q == WB_BUSY) begin
         if (wbm_ack_i || to_cnt_q == CNT_LAST) begin
            wb_state_d = WB_IDLE;
            cyc_d      = 1'b0;
            stb_d      = 1'b0;
            we_d       = 1'b0;
            sel_d      = 4'h0;
            err_d      = ~wbm_ack_i;
            if (!we_q) begin
               rdata_d = wbm_ack_i ? wbm_dat_i : ERR_DATA;
            end
         end else begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
         end
      end

      if (l_valid) begin
         wb_state_d = WB_BUSY;
         cyc_d      = 1'b1;
         stb_d      = 1'b1;
         we_d       = l_we;
         adr_d      = l_adr;
         dat_d      = l_dat;
         sel_d      = 4'hF;
         to_cnt_d   = '0;
      end

      busy_d = (state_d != S_IDLE) | (wb_state_d == WB_BUSY) | pend_d;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sclk_sync_q <= 3'b000;
         csn_sync_q  <= 3'b111;
         mosi_sync_q <= 2'b00;
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         addr_q      <= '0;
         is_write_q  <= 1'b0;
         rd_shift_q  <= '0;
         miso_q      <= 1'b0;
         oeb_q       <= 1'b1;
         wb_state_q  <= WB_IDLE;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= 4'h0;
         to_cnt_q    <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_we_q   <= 1'b0;
         pend_adr_q  <= '0;
         pend_dat_q  <= '0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         csn_sync_q  <= csn_sync_d;
         mosi_sync_q <= mosi_sync_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         addr_q      <= addr_d;
         is_write_q  <= is_write_d;
         rd_shift_q  <= rd_shift_d;
         miso_q      <= miso_d;
         oeb_q       <= oeb_d;
         wb_state_q  <= wb_state_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         to_cnt_q    <= to_cnt_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         pend_q      <= pend_d;
         pend_we_q   <= pend_we_d;
         pend_adr_q  <= pend_adr_d;
         pend_dat_q  <= pend_dat_d;
      end
   end

   assign spi_miso_o     = miso_q;
   assign spi_miso_oeb_o = oeb_q;
   assign wbm_cyc_o      = cyc_q;
   assign wbm_stb_o      = stb_q;
   assign wbm_we_o       = we_q;
   assign wbm_adr_o      = adr_q;
   assign wbm_dat_o      = dat_q;
   assign wbm_sel_o      = sel_q;
   assign err_o          = err_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Directed bench for spi_wb_bridge: a table of SPI frames with hand-computed
// Wishbone/MISO results, plus abort and async-reset sequences.
`timescale 1ns/1ps
module tb_spi_wb_bridge;

   localparam int HALF = 80;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b0;
   logic        csn = 1'b1;
   logic        mosi = 1'b0;
   logic        miso, miso_oeb;
   logic        cyc, stb, we, err, busy;
   logic [31:0] adr, dat_o;
   logic [3:0]  sel;
   logic [31:0] slave_data = '0;
   logic        ack = 1'b0;

   int pass_cnt = 0;
   int total_cnt = 0;

   int          ack_delay = 0;
   bit          ack_en = 1'b1;
   int          wait_cnt = 0;
   int          n_acc = 0;
   int          err_cnt = 0;
   int          stb_run = 0;
   bit          prev_stb = 1'b0;
   bit          prev_cyc = 1'b0;
   bit          chk_drop = 1'b0;
   bit          drop_ok = 1'b0;
   logic [31:0] m_adr = '0;
   logic [31:0] m_dat = '0;
   logic        m_we = 1'b0;
   logic [3:0]  m_sel = '0;

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      bit          en;
      int          exp_acc;
      logic        exp_we;
      logic [31:0] exp_miso;
      int          exp_err;
      int          exp_run;
   } vec_t;

   vec_t vecs[6];

   spi_wb_bridge #(.TIMEOUT(48), .ERR_DATA(32'hFFFF_FFFF)) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .spi_sclk_i    (sclk),
      .spi_csn_i     (csn),
      .spi_mosi_i    (mosi),
      .spi_miso_o    (miso),
      .spi_miso_oeb_o(miso_oeb),
      .wbm_cyc_o     (cyc),
      .wbm_stb_o     (stb),
      .wbm_we_o      (we),
      .wbm_adr_o     (adr),
      .wbm_dat_o     (dat_o),
      .wbm_sel_o     (sel),
      .wbm_dat_i     (slave_data),
      .wbm_ack_i     (ack),
      .err_o         (err),
      .busy_o        (busy)
   );

   // 100 MHz system clock; posedges land at 5, 15, 25 ns so stimulus on 10 ns steps stays clear
   always #5 clk = ~clk;

   // Bus monitor: counts new cycles, records the launched access, stb length and err pulses
   always @(posedge clk) begin
      if (cyc && !prev_cyc) n_acc++;
      if (stb && !prev_stb) begin
         m_adr = adr;
         m_dat = dat_o;
         m_we  = we;
         m_sel = sel;
      end
      if (stb) stb_run = prev_stb ? stb_run + 1 : 1;
      if (stb && ack) chk_drop = 1'b1;
      if (err) err_cnt++;
      prev_stb = stb;
      prev_cyc = cyc;
   end

   // Slave model: acks after ack_delay stb cycles, and notes whether cyc/stb drop after the ack
   always @(negedge clk) begin
      if (chk_drop) begin
         drop_ok  = !cyc && !stb;
         chk_drop = 1'b0;
      end
      if (stb && !ack && ack_en) begin
         if (wait_cnt == ack_delay) ack = 1'b1;
         else wait_cnt++;
      end else begin
         ack = 1'b0;
         if (!stb) wait_cnt = 0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic spiBit(input logic b, output logic m);
      mosi = b;
      #(HALF);
      sclk = 1'b1;
      m = miso;
      #(HALF);
      sclk = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      repeat (6) @(negedge clk);
      for (int i = 0; i < 400 && busy; i++) @(negedge clk);
      checkOutput(name, 32'(busy), 32'd0);
   endtask

   task automatic clearMonitor();
      n_acc   = 0;
      err_cnt = 0;
      stb_run = 0;
      drop_ok = 1'b0;
      m_adr   = '0;
      m_dat   = '0;
      m_we    = 1'b0;
      m_sel   = '0;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      logic [79:0] frame;
      logic [31:0] miso_word;
      logic        miso_other;
      logic        mb;
      int          nbits;
      slave_data = v.rdata;
      ack_delay  = v.delay;
      ack_en     = v.en;
      clearMonitor();
      miso_word  = '0;
      miso_other = 1'b0;
      if (v.cmd == 8'h02) begin
         frame = {v.cmd, v.addr, v.wdata, 8'h00};
         nbits = 72;
      end else if (v.cmd == 8'h03) begin
         frame = {v.cmd, v.addr, 40'h0};
         nbits = 80;
      end else begin
         frame = {v.cmd, v.addr, v.wdata, 8'hA5};
         nbits = 80;
      end
      csn = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         spiBit(frame[79-i], mb);
         if (v.cmd == 8'h03 && i >= 48) miso_word = {miso_word[30:0], mb};
         else miso_other = miso_other | mb;
      end
      #(HALF);
      csn = 1'b1;
      waitIdle($sformatf("v%0d_busy_idle", idx));
      checkOutput($sformatf("v%0d_n_access", idx), 32'(n_acc), 32'(v.exp_acc));
      if (v.exp_acc > 0) begin
         checkOutput($sformatf("v%0d_adr", idx), m_adr, v.addr);
         checkOutput($sformatf("v%0d_we", idx), 32'(m_we), 32'(v.exp_we));
         checkOutput($sformatf("v%0d_sel", idx), 32'(m_sel), 32'hF);
         if (v.exp_we) checkOutput($sformatf("v%0d_dat", idx), m_dat, v.wdata);
         if (v.en) checkOutput($sformatf("v%0d_drop_after_ack", idx), 32'(drop_ok), 32'd1);
      end
      checkOutput($sformatf("v%0d_miso_rdata", idx), miso_word, v.exp_miso);
      checkOutput($sformatf("v%0d_miso_zero_elsewhere", idx), 32'(miso_other), 32'd0);
      checkOutput($sformatf("v%0d_err_pulses", idx), 32'(err_cnt), 32'(v.exp_err));
      if (v.exp_run != 0) checkOutput($sformatf("v%0d_stb_cycles", idx), 32'(stb_run), 32'(v.exp_run));
      repeat (20) @(negedge clk);
   endtask

   initial begin
      logic        mb;
      logic [59:0] partial;
      logic [39:0] rhead;
      // cmd, addr, wdata, slave rdata, delay, ack_en, accesses, we, miso word, err, stb len
      vecs[0] = '{8'h02, 32'h0000_0010, 32'hCAFE_BABE, 32'h0, 2, 1'b1, 1, 1'b1, 32'h0, 0, 0};
      vecs[1] = '{8'h03, 32'h0000_0020, 32'h0, 32'h1234_5678, 3, 1'b1, 1, 1'b0, 32'h1234_5678, 0, 0};
      vecs[2] = '{8'h55, 32'h0000_0020, 32'hAAAA_AAAA, 32'h0, 0, 1'b1, 0, 1'b0, 32'h0, 0, 0};
      vecs[3] = '{8'h03, 32'h0000_0030, 32'h0, 32'h5555_5555, 0, 1'b0, 1, 1'b0, 32'hFFFF_FFFF, 1, 48};
      vecs[4] = '{8'h02, 32'h0000_0004, 32'h0000_0001, 32'h0, 0, 1'b1, 1, 1'b1, 32'h0, 0, 0};
      vecs[5] = '{8'h03, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_0F0F, 0, 1'b1, 1, 1'b0, 32'hA5A5_0F0F, 0, 0};

      #20;
      checkOutput("rst_cyc", 32'(cyc), 32'd0);
      checkOutput("rst_stb", 32'(stb), 32'd0);
      checkOutput("rst_we", 32'(we), 32'd0);
      checkOutput("rst_adr", adr, 32'd0);
      checkOutput("rst_dat", dat_o, 32'd0);
      checkOutput("rst_sel", 32'(sel), 32'd0);
      checkOutput("rst_miso", 32'(miso), 32'd0);
      checkOutput("rst_oeb", 32'(miso_oeb), 32'd1);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      #10 rst = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] CS abort after 20 write-data bits");
      clearMonitor();
      ack_en  = 1'b1;
      partial = {8'h02, 32'h0000_0040, 20'hDEADB};
      csn = 1'b0;
      for (int i = 0; i < 60; i++) spiBit(partial[59-i], mb);
      #(HALF);
      csn = 1'b1;
      repeat (100) @(negedge clk);
      checkOutput("abort_n_access", 32'(n_acc), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_oeb", 32'(miso_oeb), 32'd1);

      for (int i = 0; i < 6; i++) begin
         $display("[TB] vector %0d cmd=%h addr=%h", i, vecs[i].cmd, vecs[i].addr);
         applyStimulus(vecs[i], i);
      end

      $display("[TB] async reset while stb is high");
      ack_en = 1'b0;
      rhead  = {8'h03, 32'h0000_0080};
      csn = 1'b0;
      for (int i = 0; i < 40; i++) spiBit(rhead[39-i], mb);
      for (int i = 0; i < 200 && !stb; i++) @(negedge clk);
      checkOutput("arst_stb_seen", 32'(stb), 32'd1);
      #1 rst = 1'b1;
      #1;
      checkOutput("arst_cyc", 32'(cyc), 32'd0);
      checkOutput("arst_stb", 32'(stb), 32'd0);
      checkOutput("arst_adr", adr, 32'd0);
      checkOutput("arst_sel", 32'(sel), 32'd0);
      checkOutput("arst_oeb", 32'(miso_oeb), 32'd1);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      csn = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("post_rst_cyc", 32'(cyc), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Hard stop in case a bounded wait was mis-sized
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got expired, expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

endmodule
